// File: rtl/biss_pkg.sv
// Shared BiSS-C definitions: frame FSM state codes, CRC-6 constants and a
// position sign-extension helper used by the sniffer and the BiSS master.
package biss_pkg;

    localparam int CRC_WIDTH = 6;
    // x^6 + x + 1 with the implicit x^6 term dropped
    localparam logic [CRC_WIDTH-1:0] CRC_POLY = 6'h03;

    localparam int STATE_W = 4;
    localparam logic [STATE_W-1:0] ST_IDLE    = 4'd0;
    localparam logic [STATE_W-1:0] ST_ACK     = 4'd1;
    localparam logic [STATE_W-1:0] ST_START   = 4'd2;
    localparam logic [STATE_W-1:0] ST_CDS     = 4'd3;
    localparam logic [STATE_W-1:0] ST_DATA    = 4'd4;
    localparam logic [STATE_W-1:0] ST_NE      = 4'd5;
    localparam logic [STATE_W-1:0] ST_NW      = 4'd6;
    localparam logic [STATE_W-1:0] ST_CRC     = 4'd7;
    localparam logic [STATE_W-1:0] ST_TIMEOUT = 4'd8;

    // Replicates bit n-1 above the n-bit field; n=0 or n>=32 passes v through.
    function automatic logic [31:0] sign_extend(input logic [31:0] v, input logic [7:0] n);
        logic [31:0] r;
        logic [4:0]  msb;
        r   = v;
        msb = 5'(n - 8'd1);
        if (n != 8'd0 && n < 8'd32) begin
            for (int i = 0; i < 32; i++) begin
                if (i >= int'(n)) r[i] = v[msb];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/biss_crc6.sv
// Serial CRC-6 (x^6+x+1, initial value 0), one message bit per enabled cycle.
module biss_crc6
    import biss_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic                 bit_i,
    output logic [CRC_WIDTH-1:0] crc_o
);

    logic [CRC_WIDTH-1:0] crc_q;
    logic [CRC_WIDTH-1:0] crc_d;
    logic                 fb;

    always_comb begin
        fb    = crc_q[CRC_WIDTH-1] ^ bit_i;
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = '0;
        end else if (en_i) begin
            crc_d = {crc_q[CRC_WIDTH-2:0], 1'b0} ^ ({CRC_WIDTH{fb}} & CRC_POLY);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/biss_sniffer.sv
// Passive BiSS-C decoder: watches MA/SLO, checks CRC-6 and publishes position,
// link and error flags. After reset it waits for an idle line before locking on.
module biss_sniffer
    import biss_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int ABORT_CYCLES = 4096
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [7:0]  BITS,
    input  logic        ssi_sck_i,
    input  logic        ssi_dat_i,
    output logic [31:0] posn_o,
    output logic        link_up_o,
    output logic        error_o
);

    localparam int                CNT_W   = $clog2(ABORT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(ABORT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   sck_dly_q;
    logic                   sck_s;
    logic                   dat_s;
    logic                   ma_rise;
    logic                   ma_fall;
    logic                   ma_edge;
    logic                   quiet_lim;

    logic [STATE_W-1:0]   state_q,    state_d;
    logic [7:0]           bits_q,     bits_d;
    logic [7:0]           bitcnt_q,   bitcnt_d;
    logic [31:0]          shift_q,    shift_d;
    logic [CRC_WIDTH-1:0] crc_rx_q,   crc_rx_d;
    logic                 ne_q,       ne_d;
    logic                 done_q,     done_d;
    logic                 armed_q,    armed_d;
    logic [CNT_W-1:0]     idle_cnt_q, idle_cnt_d;
    logic [31:0]          posn_q,     posn_d;
    logic                 link_q,     link_d;
    logic                 err_q,      err_d;

    logic                 crc_clr;
    logic                 crc_en;
    logic [CRC_WIDTH-1:0] crc_rem;

    // sck and dat share the same chain length so SLO is sampled coherently
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            sck_sync_q <= '0;
            dat_sync_q <= '0;
            sck_dly_q  <= 1'b0;
        end else begin
            sck_sync_q <= (sck_sync_q << 1) | SYNC_STAGES'(ssi_sck_i);
            dat_sync_q <= (dat_sync_q << 1) | SYNC_STAGES'(ssi_dat_i);
            sck_dly_q  <= sck_s;
        end
    end

    assign sck_s     = sck_sync_q[SYNC_STAGES-1];
    assign dat_s     = dat_sync_q[SYNC_STAGES-1];
    assign ma_rise   = sck_s & ~sck_dly_q;
    assign ma_fall   = ~sck_s & sck_dly_q;
    assign ma_edge   = ma_rise | ma_fall;
    assign quiet_lim = ~ma_edge && (idle_cnt_q == CNT_LIM);

    biss_crc6 u_crc (
        .clk_i  (clk_i),
        .rst_ni (reset_i),
        .clr_i  (crc_clr),
        .en_i   (crc_en),
        .bit_i  (dat_s),
        .crc_o  (crc_rem)
    );

    always_comb begin
        state_d    = state_q;
        bits_d     = bits_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        crc_rx_d   = crc_rx_q;
        ne_d       = ne_q;
        done_d     = 1'b0;
        armed_d    = armed_q;
        posn_d     = posn_q;
        link_d     = link_q;
        err_d      = err_q;
        crc_clr    = 1'b0;
        crc_en     = 1'b0;
        idle_cnt_d = ma_edge ? '0 : ((idle_cnt_q == CNT_LIM) ? idle_cnt_q : idle_cnt_q + 1'b1);

        case (state_q)
            ST_IDLE: begin
                // Falling edges are ignored until MA has been quiet and high long enough
                if (!armed_q) begin
                    if (quiet_lim && sck_s) armed_d = 1'b1;
                end else if (ma_fall) begin
                    bits_d   = BITS;
                    shift_d  = '0;
                    crc_rx_d = '0;
                    ne_d     = 1'b0;
                    crc_clr  = 1'b1;
                    state_d  = ST_ACK;
                end
            end
            ST_ACK: begin
                if (ma_rise && !dat_s) state_d = ST_START;
            end
            ST_START: begin
                if (ma_rise && dat_s) state_d = ST_CDS;
            end
            ST_CDS: begin
                if (ma_rise) begin
                    if (bits_q == 8'd0) begin
                        state_d = ST_NE;
                    end else begin
                        bitcnt_d = bits_q - 8'd1;
                        state_d  = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (ma_rise) begin
                    shift_d = {shift_q[30:0], dat_s};
                    crc_en  = 1'b1;
                    if (bitcnt_q == 8'd0) state_d = ST_NE;
                    else                  bitcnt_d = bitcnt_q - 8'd1;
                end
            end
            ST_NE: begin
                if (ma_rise) begin
                    ne_d    = dat_s;
                    crc_en  = 1'b1;
                    state_d = ST_NW;
                end
            end
            ST_NW: begin
                // nW only feeds the CRC; it is not reported anywhere
                if (ma_rise) begin
                    crc_en   = 1'b1;
                    bitcnt_d = 8'(CRC_WIDTH - 1);
                    state_d  = ST_CRC;
                end
            end
            ST_CRC: begin
                if (ma_rise) begin
                    crc_rx_d = {crc_rx_q[CRC_WIDTH-2:0], dat_s};
                    if (bitcnt_q == 8'd0) begin
                        done_d  = 1'b1;
                        state_d = ST_TIMEOUT;
                    end else begin
                        bitcnt_d = bitcnt_q - 8'd1;
                    end
                end
            end
            ST_TIMEOUT: begin
                if (sck_s && dat_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q != ST_IDLE && state_q != ST_TIMEOUT && quiet_lim) begin
            state_d = ST_IDLE;
            link_d  = 1'b0;
            err_d   = 1'b1;
        end

        // Slave transmits the inverted remainder
        if (done_q) begin
            if (crc_rx_q == ~crc_rem) begin
                posn_d = sign_extend(shift_q, bits_q);
                link_d = 1'b1;
                err_d  = ~ne_q;
            end else begin
                link_d = 1'b0;
                err_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= ST_IDLE;
            bits_q     <= '0;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            crc_rx_q   <= '0;
            ne_q       <= 1'b0;
            done_q     <= 1'b0;
            armed_q    <= 1'b0;
            idle_cnt_q <= '0;
            posn_q     <= '0;
            link_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bits_q     <= bits_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            crc_rx_q   <= crc_rx_d;
            ne_q       <= ne_d;
            done_q     <= done_d;
            armed_q    <= armed_d;
            idle_cnt_q <= idle_cnt_d;
            posn_q     <= posn_d;
            link_q     <= link_d;
            err_q      <= err_d;
        end
    end

    assign posn_o    = posn_q;
    assign link_up_o = link_q;
    assign error_o   = err_q;

endmodule

// File: tb/tb_biss_sniffer.sv
// Bench for biss_sniffer: drives BiSS-C frames on MA/SLO and compares the
// published position and flags with a polynomial-division reference model.
module tb_biss_sniffer;

    localparam int SYNC  = 2;
    localparam int ABORT = 4096;
    localparam int H     = 4;

    logic        clk;
    logic        reset_n;
    logic        sck;
    logic        dat;
    logic [7:0]  bits;
    logic [31:0] posn;
    logic        link;
    logic        err;

    int          checks;
    int          failures;
    logic [31:0] exp_posn;
    logic        exp_link;
    logic        exp_err;
    logic [31:0] nxt_posn;
    logic        nxt_link;
    logic        nxt_err;
    bit          frame_q[$];

    biss_sniffer #(
        .SYNC_STAGES  (SYNC),
        .ABORT_CYCLES (ABORT)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset_n),
        .BITS      (bits),
        .ssi_sck_i (sck),
        .ssi_dat_i (dat),
        .posn_o    (posn),
        .link_up_o (link),
        .error_o   (err)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    // Long division of msg(x)*x^6 by x^6+x+1
    function automatic logic [5:0] crc6_remainder(input bit msg[$]);
        bit         a[$];
        logic [6:0] gen;
        logic [5:0] r;
        gen = 7'b1000011;
        a   = msg;
        repeat (6) a.push_back(1'b0);
        for (int i = 0; i < msg.size(); i++) begin
            if (a[i]) begin
                for (int k = 0; k < 7; k++) a[i+k] = a[i+k] ^ gen[6-k];
            end
        end
        for (int j = 0; j < 6; j++) r[5-j] = a[msg.size()+j];
        return r;
    endfunction

    task automatic build_frame(input int nbits, input logic [63:0] data, input bit ne,
                               input bit nw, input bit bad);
        bit         msg[$];
        logic [5:0] tx;
        longint     m;
        longint     v;
        int         flip;
        for (int i = nbits - 1; i >= 0; i--) msg.push_back(data[i]);
        msg.push_back(ne);
        msg.push_back(nw);
        tx = ~crc6_remainder(msg);
        if (bad) begin
            flip     = int'($urandom_range(5, 0));
            tx[flip] = ~tx[flip];
        end
        frame_q.delete();
        frame_q.push_back(1'b1);
        frame_q.push_back(1'b0);
        frame_q.push_back(1'b1);
        frame_q.push_back(1'b0);
        foreach (msg[i]) frame_q.push_back(msg[i]);
        for (int j = 5; j >= 0; j--) frame_q.push_back(tx[j]);
        if (bad) begin
            nxt_posn = exp_posn;
            nxt_link = 1'b0;
            nxt_err  = 1'b1;
        end else begin
            if (nbits >= 32) begin
                v = longint'(data[31:0]);
            end else begin
                m = longint'(1) << nbits;
                v = longint'(data) & (m - 1);
                if (v >= m / 2) v = v - m;
            end
            nxt_posn = v[31:0];
            nxt_link = 1'b1;
            nxt_err  = ~ne;
        end
    endtask

    task automatic send_bits(input int first, input int last);
        for (int i = first; i < last; i++) begin
            sck = 1'b0;
            dat = frame_q[i];
            repeat (H) @(negedge clk);
            sck = 1'b1;
            repeat (H) @(negedge clk);
        end
    endtask

    task automatic line_tail();
        repeat (H) @(negedge clk);
        dat = 1'b0;
        repeat (2 * H) @(negedge clk);
        dat = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    task automatic run_frame(input string name, input int nbits, input logic [63:0] data,
                             input bit ne, input bit bad);
        int n;
        bits = 8'(nbits);
        build_frame(nbits, data, ne, 1'($urandom_range(1, 0)), bad);
        n = frame_q.size();
        send_bits(0, 6);
        bits = 8'($urandom);
        send_bits(6, n - 1);
        sck = 1'b0;
        dat = frame_q[n-1];
        repeat (H) @(negedge clk);
        sck = 1'b1;
        repeat (SYNC + 1) @(posedge clk);
        #1;
        checks++;
        if (posn !== exp_posn || link !== exp_link || err !== exp_err) begin
            failures++;
            $display("FAIL %s early: posn=%h link=%b err=%b, required unchanged %h %b %b",
                     name, posn, link, err, exp_posn, exp_link, exp_err);
        end
        @(posedge clk);
        #1;
        exp_posn = nxt_posn;
        exp_link = nxt_link;
        exp_err  = nxt_err;
        checks++;
        if (posn !== exp_posn) begin
            failures++;
            $display("FAIL %s posn: got %h required %h", name, posn, exp_posn);
        end
        checks++;
        if (link !== exp_link) begin
            failures++;
            $display("FAIL %s link_up: got %b required %b", name, link, exp_link);
        end
        checks++;
        if (err !== exp_err) begin
            failures++;
            $display("FAIL %s error: got %b required %b", name, err, exp_err);
        end
        line_tail();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (posn !== 32'h0 || link !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset: posn=%h link=%b err=%b, required 0 0 0", posn, link, err);
        end
        reset_n = 1'b1;
        repeat (ABORT + 20) @(negedge clk);
        checks++;
        if (posn !== 32'h0 || link !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: posn=%h link=%b err=%b, required 0 0 0", posn, link, err);
        end
    endtask

    task automatic test_good32();
        run_frame("good32", 32, 64'h0000_0000_1234_5678, 1'b1, 1'b0);
    endtask

    task automatic test_sign16();
        run_frame("sign16_neg", 16, 64'h8001, 1'b1, 1'b0);
        run_frame("sign16_pos", 16, 64'h7FFF, 1'b1, 1'b0);
    endtask

    task automatic test_crc_error();
        run_frame("crc_good", 32, 64'h0AAA, 1'b1, 1'b0);
        run_frame("crc_bad", 32, 64'h0BBB, 1'b1, 1'b1);
        run_frame("crc_recover", 32, 64'h0CCC, 1'b1, 1'b0);
    endtask

    task automatic test_ne();
        run_frame("ne_low", 32, 64'h55, 1'b0, 1'b0);
        run_frame("ne_high", 32, 64'h66, 1'b1, 1'b0);
    endtask

    task automatic test_random_back_to_back();
        int          nb;
        logic [63:0] d;
        for (int k = 0; k < 10; k++) begin
            nb = int'($urandom_range(40, 1));
            d  = {$urandom, $urandom};
            run_frame("random", nb, d, 1'($urandom_range(1, 0)), ($urandom_range(3, 0) == 0));
        end
    endtask

    task automatic test_abort();
        bits = 8'd32;
        build_frame(32, 64'hCAFE_F00D, 1'b1, 1'b1, 1'b0);
        send_bits(0, 14);
        sck = 1'b0;
        repeat (ABORT + 10) @(negedge clk);
        exp_link = 1'b0;
        exp_err  = 1'b1;
        checks++;
        if (posn !== exp_posn) begin
            failures++;
            $display("FAIL abort posn: got %h required %h", posn, exp_posn);
        end
        checks++;
        if (link !== exp_link || err !== exp_err) begin
            failures++;
            $display("FAIL abort flags: link=%b err=%b, required %b %b", link, err, exp_link, exp_err);
        end
        sck = 1'b1;
        dat = 1'b1;
        repeat (4 * H) @(negedge clk);
        run_frame("after_abort", 24, 64'h00AB_CDEF, 1'b1, 1'b0);
    endtask

    task automatic test_reset_midframe();
        bits = 8'd32;
        build_frame(32, {32'h0, $urandom}, 1'b1, 1'b0, 1'b0);
        send_bits(0, 20);
        #2 reset_n = 1'b0;
        #1;
        exp_posn = 32'h0;
        exp_link = 1'b0;
        exp_err  = 1'b0;
        checks++;
        if (posn !== exp_posn || link !== exp_link || err !== exp_err) begin
            failures++;
            $display("FAIL async_reset: posn=%h link=%b err=%b, required 0 0 0", posn, link, err);
        end
        @(negedge clk);
        reset_n = 1'b1;
        send_bits(20, frame_q.size());
        line_tail();
        repeat (10 * H) @(negedge clk);
        checks++;
        if (posn !== exp_posn || link !== exp_link || err !== exp_err) begin
            failures++;
            $display("FAIL partial_frame: posn=%h link=%b err=%b, required 0 0 0", posn, link, err);
        end
        repeat (ABORT + 20) @(negedge clk);
        run_frame("after_reset", 20, 64'hF_1234, 1'b1, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        sck      = 1'b1;
        dat      = 1'b1;
        bits     = 8'd32;
        exp_posn = 32'h0;
        exp_link = 1'b0;
        exp_err  = 1'b0;
        nxt_posn = 32'h0;
        nxt_link = 1'b0;
        nxt_err  = 1'b0;
        test_reset();
        test_good32();
        test_sign16();
        test_crc_error();
        test_ne();
        test_random_back_to_back();
        test_abort();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/biss_sniffer.md
Name: biss_sniffer

Overview:
Passive BiSS-C frame decoder. It monitors an existing master clock (MA) and slave data line (SLO) pair without driving either. It extracts the BITS-wide position word, checks the 6-bit CRC and status bits, and publishes the position plus link and error flags. It sits in the encoder input path beside the SSI sniffer and feeds the position bus.

Parameters:
SYNC_STAGES, 2, number of flip-flops in the synchroniser on ssi_sck_i and ssi_dat_i.
ABORT_CYCLES, 4096, number of clk_i cycles with no MA edge inside a frame (outside IDLE/TIMEOUT) that aborts the frame.

Ports:
clk_i  in  1  system clock, 125 MHz nominal.
reset_i  in  1  reset; asynchronous, active-low.
BITS  in  8  number of position bits per frame; sampled when a frame starts.
ssi_sck_i  in  1  MA line, asynchronous to clk_i, idles high.
ssi_dat_i  in  1  SLO line, asynchronous to clk_i, idles high.
posn_o  out  32  last good position, sign-extended.
link_up_o  out  1  high after a good frame.
error_o  out  1  high when the last completed or aborted frame was bad.

Behaviour:
- Reset (reset_i=0, asynchronous): posn_o=0, link_up_o=0, error_o=0, state=IDLE, all counters and shift registers cleared.
- Synchronisation: both inputs pass through SYNC_STAGES flops, then one edge-detect flop. sck and dat get identical delay. SLO is sampled on each synchronised MA rising edge ("bit" below).
- Input rate: inputs may change every clk_i cycle. The MA half-period is at least 2 clk_i cycles.
- States and transitions:
  IDLE: wait for a falling edge of MA, then latch BITS and go to ACK.
  ACK: wait for a bit with dat=0, then go to START.
  START: wait for a bit with dat=1, then go to CDS.
  CDS: ignore 1 bit; go to DATA, or to NE if the latched BITS=0.
  DATA: shift in BITS bits, MSB first, into a 32-bit shift register. If BITS>32, only the last 32 bits are kept.
  NE: 1 bit; nE, active-low error.
  NW: 1 bit; nW, active-low warning.
  CRC: 6 bits, MSB first.
  TIMEOUT: wait for synchronised dat=1 with sck=1, then go to IDLE.
- CRC:
  - Polynomial x^6+x+1 (0x43), initial value 0.
  - Computed serially over the DATA, nE and nW bits only.
  - The transmitted CRC is the bitwise inverse of the computed remainder.
- Frame result, registered on the clk_i edge after the last CRC bit is sampled:
  - CRC match and nE=1: posn_o = data, sign-extended from bit BITS-1 when BITS<32; link_up_o=1; error_o=0.
  - CRC match and nE=0: posn_o updated as above; link_up_o=1; error_o=1.
  - CRC mismatch: posn_o holds its previous value; link_up_o=0; error_o=1.
- Latency: a new posn_o is visible SYNC_STAGES+2 clk_i cycles after the last CRC MA rising edge on the pin.
- nW is captured but does not affect any output.
- Abort: ABORT_CYCLES cycles with no MA edge while in any state other than IDLE or TIMEOUT sends the FSM to IDLE with link_up_o=0, error_o=1, posn_o held.
- A BITS change mid-frame takes effect at the next frame.
- When reset is released mid-frame, the FSM starts in IDLE. It resynchronises at the next MA falling edge after the line has been idle. Any partial frame is ignored until TIMEOUT/IDLE is reached via the abort path or a normal frame end.
- Outputs change only at frame end or on abort; they are stable between frames.

Decomposition:
- Shared package biss_pkg:
  - state enum (IDLE, ACK, START, CDS, DATA, NE, NW, CRC, TIMEOUT);
  - CRC_POLY=6'h03 (x^6+x+1 without the x^6 term);
  - CRC_WIDTH=6.
- One sub-module, biss_crc6: serial CRC-6 with clear, enable and data-bit inputs, and a 6-bit remainder output. It is reused by the BiSS master.
- The synchroniser uses the existing common sync-bit cell.

Test Plan:
- BITS=32, data 0x12345678, nE=1, nW=1, correct inverted CRC, MA half-period 4 clk_i -> posn_o=0x12345678, link_up_o=1, error_o=0, within SYNC_STAGES+2 cycles of the last CRC edge.
- BITS=16, data 0x8001, valid CRC -> posn_o=0xFFFF8001. Then data 0x7FFF -> posn_o=0x00007FFF.
- BITS=32, good frame 0x00000AAA, then a frame 0x00000BBB with one CRC bit flipped -> posn_o stays 0x00000AAA, link_up_o=0, error_o=1. The next good frame restores link_up_o=1, error_o=0.
- Valid frame with nE=0, data 0x00000055 -> posn_o=0x00000055, link_up_o=1, error_o=1.
- MA held low for ABORT_CYCLES+10 cycles mid-DATA -> error_o=1, link_up_o=0, posn_o unchanged. The following good frame decodes correctly.
- Assert reset_i=0 mid-frame -> outputs zero asynchronously. After release, the remainder of that frame produces no posn_o update, and the next full frame decodes correctly.
